// File: rtl/cross_entropy_lut_arbiter.sv
// Round-robin, packet-locking arbiter sharing one cross-entropy gradient table
// (p -> floor(4096/(4096-p))) among NUM_REQ requesters; one registered result per beat.
module cross_entropy_lut_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IN_W         = 12,
    parameter int OUT_W        = 13,
    parameter int LOCK_TIMEOUT = 16,
    parameter int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_last,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [OUT_W-1:0]        rsp_data,
    output logic                    rsp_last,
    output logic                    lock_abort,
    output logic                    busy
);

    localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
    localparam logic [IN_W:0] FULL_SCALE = {1'b1, {IN_W{1'b0}}};

    typedef enum logic {ARB, LOCK} state_t;

    state_t              state;
    state_t              state_next;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     owner;
    logic [CNT_W-1:0]    idle_cnt;
    logic [ID_W:0]       scan;
    logic                arb_hit;
    logic [ID_W-1:0]     arb_idx;
    logic                gnt_any;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_last;
    logic [IN_W-1:0]     gnt_data;
    logic                xfer;
    logic                timeout;

    logic                vld_p1;
    logic [ID_W-1:0]     rsp_id_p1;
    logic [OUT_W-1:0]    rsp_data_p1;
    logic                rsp_last_p1;
    logic                lock_abort_p1;

    // Denominator is never zero: p tops out at FULL_SCALE-1.
    function automatic logic [OUT_W-1:0] grad_lut(input logic [IN_W-1:0] p);
        logic [IN_W:0] denom;
        denom = FULL_SCALE - {1'b0, p};
        return OUT_W'(FULL_SCALE / denom);
    endfunction

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx);
        return (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Scan from the farthest candidate down to rr_ptr so the last hit wins priority.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        scan    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (scan >= (ID_W + 1)'(NUM_REQ)) begin
                scan = scan - (ID_W + 1)'(NUM_REQ);
            end
            if (req_valid[scan[ID_W-1:0]]) begin
                arb_hit = 1'b1;
                arb_idx = scan[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        timeout    = 1'b0;
        case (state)
            ARB: begin
                if (xfer && !gnt_last) begin
                    state_next = LOCK;
                end
            end
            LOCK: begin
                if (xfer) begin
                    if (gnt_last) begin
                        state_next = ARB;
                    end
                end else if ((LOCK_TIMEOUT != 0) && (idle_cnt == IDLE_LIMIT)) begin
                    state_next = ARB;
                    timeout    = 1'b1;
                end
            end
            default: state_next = ARB;
        endcase
    end

    // The lock owner keeps its ready high whether or not it is presenting a beat.
    always_comb begin
        gnt_any   = (state == LOCK) | arb_hit;
        gnt_idx   = (state == LOCK) ? owner : arb_idx;
        gnt_last  = req_last[gnt_idx];
        gnt_data  = req_data[gnt_idx*IN_W +: IN_W];
        xfer      = gnt_any & req_valid[gnt_idx];
        req_ready = (rst_n && gnt_any) ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            owner         <= '0;
            idle_cnt      <= '0;
            lock_abort_p1 <= 1'b0;
        end else begin
            lock_abort_p1 <= timeout;
            if (state == ARB) begin
                if (xfer) begin
                    if (gnt_last) begin
                        rr_ptr <= next_ptr(arb_idx);
                    end else begin
                        owner    <= arb_idx;
                        idle_cnt <= '0;
                    end
                end
            end else begin
                if (xfer) begin
                    idle_cnt <= '0;
                    if (gnt_last) begin
                        rr_ptr <= next_ptr(owner);
                    end
                end else if (timeout) begin
                    rr_ptr <= next_ptr(owner);
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

    // Stage p1: registered table result; rsp_* other than valid hold between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            rsp_id_p1   <= '0;
            rsp_data_p1 <= '0;
            rsp_last_p1 <= 1'b0;
        end else begin
            vld_p1 <= xfer;
            if (xfer) begin
                rsp_id_p1   <= gnt_idx;
                rsp_data_p1 <= grad_lut(gnt_data);
                rsp_last_p1 <= gnt_last;
            end
        end
    end

    assign rsp_valid  = vld_p1;
    assign rsp_id     = rsp_id_p1;
    assign rsp_data   = rsp_data_p1;
    assign rsp_last   = rsp_last_p1;
    assign lock_abort = lock_abort_p1;
    assign busy       = (state == LOCK) | vld_p1;

endmodule

// File: tb/tb_cross_entropy_lut_arbiter.sv
// Bench for cross_entropy_lut_arbiter: vector table plus hand-written lock, timeout,
// reset and full-table sequences; responses checked through a scoreboard queue.
module tb_cross_entropy_lut_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [47:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [12:0] rsp_data;
    logic        rsp_last;
    logic        lock_abort;
    logic        busy;

    cross_entropy_lut_arbiter #(
        .NUM_REQ      (4),
        .IN_W         (12),
        .OUT_W        (13),
        .LOCK_TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
        .lock_abort (lock_abort),
        .busy       (busy)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [11:0] d0;
        logic [11:0] d1;
        logic [11:0] d2;
        logic [11:0] d3;
        logic [3:0]  exp_ready;
        logic [12:0] exp_rsp;
    } vec_t;

    typedef struct {
        int          due;
        logic [1:0]  id;
        logic [12:0] data;
        logic        last;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [12:0] golden(input int p);
        return 13'(4096 / (4096 - p));
    endfunction

    task automatic apply(input logic [3:0] v, input logic [3:0] l,
                         input logic [11:0] d0, input logic [11:0] d1,
                         input logic [11:0] d2, input logic [11:0] d3,
                         input logic [3:0] er, input logic [12:0] ersp, input string nm);
        @(posedge clk);
        #1;
        req_valid = v;
        req_last  = l;
        req_data  = {d3, d2, d1, d0};
        #1;
        check({nm, "_ready"}, 32'(req_ready), 32'(er));
        for (int i = 0; i < 4; i++) begin
            if (er[i] && v[i]) begin
                sb.push_back('{cyc + 1, 2'(i), ersp, l[i]});
            end
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_ready"}, 32'(req_ready), 32'd0);
        check({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({nm, "_rsp_id"}, 32'(rsp_id), 32'd0);
        check({nm, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({nm, "_rsp_last"}, 32'(rsp_last), 32'd0);
        check({nm, "_lock_abort"}, 32'(lock_abort), 32'd0);
        check({nm, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Scoreboard: each expected response is due exactly one cycle after its grant.
    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
            check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
            check("rsp_last", 32'(rsp_last), 32'(mon_e.last));
        end else begin
            check("rsp_idle", 32'(rsp_valid), 32'd0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        req_data  = '0;
        #1;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        check_all_zero("reset_edge");
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        req_last  = 4'b0000;

        // Single beat, then four-way round robin with wraparound, then a locked packet.
        vecs.push_back('{4'b0001, 4'b0001, 12'd0, 12'd0, 12'd0, 12'd0, 4'b0001, 13'd1});
        for (int j = 0; j < 8; j++) begin
            vecs.push_back('{4'b1111, 4'b1111, 12'd4095, 12'd4095, 12'd4095, 12'd4095,
                             4'b0001 << ((j + 1) % 4), 13'd4096});
        end
        vecs.push_back('{4'b0000, 4'b0000, 12'd0, 12'd0, 12'd0, 12'd0, 4'b0000, 13'd0});
        vecs.push_back('{4'b0111, 4'b0101, 12'd2047, 12'd3072, 12'd2048, 12'd0, 4'b0010, 13'd4});
        vecs.push_back('{4'b0111, 4'b0101, 12'd2047, 12'd4080, 12'd2048, 12'd0, 4'b0010, 13'd256});
        vecs.push_back('{4'b0101, 4'b0101, 12'd2047, 12'd0, 12'd2048, 12'd0, 4'b0010, 13'd0});
        vecs.push_back('{4'b0111, 4'b0111, 12'd2047, 12'd4094, 12'd2048, 12'd0, 4'b0010, 13'd2048});
        vecs.push_back('{4'b0101, 4'b0101, 12'd2047, 12'd0, 12'd2048, 12'd0, 4'b0100, 13'd2});
        vecs.push_back('{4'b0001, 4'b0001, 12'd2047, 12'd0, 12'd0, 12'd0, 4'b0001, 13'd1});
        vecs.push_back('{4'b0010, 4'b0010, 12'd0, 12'd4092, 12'd0, 12'd0, 4'b0010, 13'd1024});

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].valid, vecs[i].last, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3,
                  vecs[i].exp_ready, vecs[i].exp_rsp, $sformatf("vec%0d", i));
        end

        // Lock by req2 left idle until the timeout releases it.
        apply(4'b0100, 4'b0000, 12'd0, 12'd0, 12'd0, 12'd0, 4'b0100, 13'd1, "t4_lock");
        for (int k = 0; k <= 16; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("t4_abort_%0d", k), 32'(lock_abort), (k == 16) ? 32'd1 : 32'd0);
            req_valid = 4'b0000;
            req_last  = 4'b0000;
            req_data  = '0;
            #1;
            check($sformatf("t4_ready_%0d", k), 32'(req_ready), (k < 16) ? 32'd4 : 32'd0);
            check($sformatf("t4_busy_%0d", k), 32'(busy), (k < 16) ? 32'd1 : 32'd0);
        end
        apply(4'b1101, 4'b1111, 12'd0, 12'd0, 12'd2048, 12'd4095, 4'b1000, 13'd4096, "t4_after3");
        apply(4'b0101, 4'b1111, 12'd0, 12'd0, 12'd2048, 12'd4095, 4'b0001, 13'd1, "t4_after0");
        apply(4'b0100, 4'b1111, 12'd0, 12'd0, 12'd2048, 12'd4095, 4'b0100, 13'd2, "t4_after2");

        // Reset asserted while req3 holds the lock.
        apply(4'b1000, 4'b0000, 12'd0, 12'd0, 12'd0, 12'd3072, 4'b1000, 13'd4, "t5_lock");
        apply(4'b0000, 4'b0000, 12'd0, 12'd0, 12'd0, 12'd0, 4'b1000, 13'd0, "t5_idle");
        check("t5_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 4'b1001;
        req_last  = 4'b1001;
        req_data  = {12'd0, 12'd0, 12'd0, 12'd2048};
        #1;
        check_all_zero("t5_rst");
        @(posedge clk);
        #1;
        check_all_zero("t5_rst_edge");
        rst_n = 1'b1;
        #1;
        check("t5_first_ready", 32'(req_ready), 32'd1);
        sb.push_back('{cyc + 1, 2'd0, 13'd2, 1'b1});
        apply(4'b1000, 4'b1000, 12'd0, 12'd0, 12'd0, 12'd0, 4'b1000, 13'd1, "t5_second");

        // Every table entry through requester 3, one beat per cycle.
        for (int p = 0; p < 4096; p++) begin
            apply(4'b1000, 4'b1000, 12'd0, 12'd0, 12'd0, 12'(p), 4'b1000, golden(p),
                  $sformatf("sweep%0d", p));
        end

        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
